// File: rtl/lab_ms_sv4.sv
// lab_ms_sv4: registered 8-bit signed ALU with 16-bit result; NOP and unknown opcodes hold.
package lab_MS_SV4_pack;
  localparam int DATA_X_W = 8;
  localparam int DATA_Y_W = 16;
  typedef logic signed [DATA_X_W-1:0] data_x;
  typedef logic signed [DATA_Y_W-1:0] data_y;
  typedef enum logic [2:0] {ADD, SUB, MUL, AND, OR, XOR, SHL, NOP} opc_t;
  typedef struct packed {
    opc_t  opc;
    data_x op_a;
    data_x op_b;
  } INST_t;
endpackage

module lab_ms_sv4
  import lab_MS_SV4_pack::*;
(
  input  logic  clk,
  input  logic  rst,
  input  INST_t INST,
  output data_y ALU_out
);
  data_y a, b, res;
  assign a = {{(DATA_Y_W-DATA_X_W){INST.op_a[DATA_X_W-1]}}, INST.op_a};
  assign b = {{(DATA_Y_W-DATA_X_W){INST.op_b[DATA_X_W-1]}}, INST.op_b};
  always_comb begin
    res = ALU_out;
    case (INST.opc)
      ADD:     res = a + b;
      SUB:     res = a - b;
      MUL:     res = a * b;
      AND:     res = a & b;
      OR:      res = a | b;
      XOR:     res = a ^ b;
      SHL:     res = a << INST.op_b[2:0];
      default: res = ALU_out;
    endcase
  end
  always_ff @(posedge clk)
    ALU_out <= rst ? '0 : res;
endmodule

// File: tb/tb_lab_ms_sv4.sv
// tb_lab_ms_sv4: randomized + directed scoreboard bench against an arithmetic reference model.
module tb_lab_ms_sv4;
  import lab_MS_SV4_pack::*;
  logic  clk = 1'b0;
  logic  rst = 1'b1;
  INST_t inst = '0;
  data_y alu_out;
  logic signed [15:0] exp_q[$];
  logic signed [15:0] prev = '0;
  int checks = 0;
  int passes = 0;
  int id = 0;

  lab_ms_sv4 dut (.clk(clk), .rst(rst), .INST(inst), .ALU_out(alu_out));

  always #5 clk = ~clk;

  function automatic logic signed [15:0] model(opc_t o, int a, int b, logic signed [15:0] p);
    int r;
    case (o)
      ADD: r = a + b;
      SUB: r = a - b;
      MUL: r = a * b;
      AND: r = a & b;
      OR:  r = a | b;
      XOR: r = a ^ b;
      SHL: r = a * (1 << (b & 7));
      default: r = int'(p);
    endcase
    return 16'(r);
  endfunction

  task automatic drive(input opc_t o, input int a, input int b, input logic r,
                       input logic use_k, input int k);
    logic signed [15:0] e;
    inst.opc = o;
    inst.op_a = data_x'(a);
    inst.op_b = data_x'(b);
    rst = r;
    e = r ? 16'sd0 : (use_k ? 16'(k) : model(o, a, b, prev));
    prev = e;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    if (exp_q.size() != 0) begin
      logic signed [15:0] e;
      int n;
      e = exp_q.pop_front();
      n = id;
      id++;
      #1;
      checks++;
      if (alu_out === e) passes++;
      else $display("FAIL alu_out step=%0d got=%0d expected=%0d", n, alu_out, e);
    end
  end

  always @(inst or alu_out)
    $display("opc=%s op_a=%0d op_b=%0d ALU_out=%0d", inst.opc.name(), inst.op_a, inst.op_b, alu_out);

  initial begin
    int s1[7] = '{5, 15, -50, 10, -5, -15, 80};
    int s2[7] = '{0, 10, -25, 1, -1, -2, 40};
    drive(NOP, 0, 0, 1'b1, 1'b1, 0);
    drive(ADD, 3, 4, 1'b1, 1'b1, 0);
    for (int i = 0; i < 7; i++) drive(opc_t'(i), 10, -5, 1'b0, 1'b1, s1[i]);
    for (int i = 0; i < 7; i++) drive(opc_t'(i), 5, -5, 1'b0, 1'b1, s2[i]);
    drive(ADD, 10, -5, 1'b0, 1'b1, 5);
    for (int i = 0; i < 3; i++) drive(NOP, 100 - i, -i, 1'b0, 1'b1, 5);
    drive(MUL, -128, -128, 1'b1, 1'b1, 0);
    drive(MUL, -128, -128, 1'b0, 1'b1, 16384);
    drive(NOP, 7, 7, 1'b1, 1'b1, 0);
    drive(NOP, 7, 7, 1'b0, 1'b1, 0);
    drive(SHL, -128, 7, 1'b0, 1'b1, -16384);
    drive(SUB, -128, 127, 1'b0, 1'b1, -255);
    drive(MUL, 127, -128, 1'b0, 1'b1, -16256);
    drive(MUL, -128, -128, 1'b0, 1'b1, 16384);
    for (int i = 0; i < 300; i++)
      drive(opc_t'(3'($urandom_range(0, 7))), int'($urandom_range(0, 255)) - 128,
            int'($urandom_range(0, 255)) - 128, ($urandom_range(0, 19) == 0), 1'b0, 0);
    rst = 1'b0;
    inst.opc = NOP;
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain pending=%0d expected=0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/lab_ms_sv4.md
LAB_MS_SV4 -- requirements
Module: lab_ms_sv4

Interface
- REQ-001 The module SHALL take all types from package lab_MS_SV4_pack: data_x = signed 8-bit operand, data_y = signed 16-bit result, opc_t = 3-bit enum, INST_t = packed struct {opc_t opc; data_x op_a; data_x op_b} (19 bits, opc in MSBs).
- REQ-002 opc_t encoding SHALL be ADD=0, SUB=1, MUL=2, AND=3, OR=4, XOR=5, SHL=6, NOP=7; NOP is the last enum member.
- REQ-003 Parameters: none on the module; package constants DATA_X_W = 8 (operand width) and DATA_Y_W = 16 (result width).
- REQ-004 Ports (name, direction, width, meaning), one clock, reset synchronous and active-high:
  - clk, input, 1: rising-edge clock.
  - rst, input, 1: synchronous active-high reset.
  - INST, input, INST_t (19): opcode plus two operands, sampled every clk edge.
  - ALU_out, output, data_y (16): registered signed result.

Function
- REQ-005 Both operands SHALL be sign-extended to 16 bits before any operation.
- REQ-006 Operations, where a and b are the sign-extended op_a and op_b:
  - ADD: a+b.
  - SUB: a-b.
  - MUL: a*b, full signed 16-bit product.
  - AND: a&b.
  - OR: a|b.
  - XOR: a^b.
  - SHL: a << op_b[2:0]. The shift amount is unsigned and the 16-bit result is not truncated to 8 bits.
- REQ-007 No 16-bit overflow is possible for 8-bit operands. No saturation, flags or wrap handling are required.
- REQ-008 NOP SHALL leave ALU_out unchanged (hold the previous value).
- REQ-009 ALU_out SHALL be a register updated on each rising clk edge from the INST value present at that edge. Latency is exactly 1 cycle, with no handshake and no stall.
- REQ-010 The ALU combinational path SHALL use a single case statement on INST.opc. Any undefined or X opcode SHALL produce a hold, identical to NOP.
- REQ-011 Back-to-back opcode changes on consecutive cycles SHALL each produce their own result one cycle later, with no bubbles.

Reset
- REQ-012 When rst=1 at a rising clk edge, ALU_out SHALL become 16'sd0, regardless of INST.
- REQ-013 Reset SHALL take priority over any opcode, including NOP.
- REQ-014 After reset is released, the first valid result SHALL appear one cycle after the first sampled non-NOP instruction.
- REQ-015 Reset asserted mid-sequence SHALL discard the pending result. No state other than ALU_out exists.

Verification
- REQ-016 op_a=10, op_b=-5, opc swept ADD..SHL one per cycle -> ALU_out sequence 5, 15, -50, 10, -5, -15, 80, each one cycle after its opcode.
- REQ-017 op_a=5, op_b=-5, same sweep -> 0, 10, -25, 1, -1, -2, 40.
- REQ-018 ADD 10,-5 followed by NOP for 3 cycles -> ALU_out stays 5.
- REQ-019 rst=1 while opc=MUL, op_a=-128, op_b=-128 -> ALU_out=0. After rst drops, the next cycle gives 16384.
- REQ-020 Extreme values:
  - SHL op_a=-128, op_b=7 -> -16384.
  - SUB op_a=-128, op_b=127 -> -255.
  - MUL op_a=127, op_b=-128 -> -16256.
- REQ-021 A bench monitor SHALL print opc (by name), op_a, op_b and ALU_out on every change. A self-check SHALL compare against a reference model delayed by 1 cycle.
